// File: rtl/aes_ctr_ctrl.sv
// =====================================================================
// Module   : aes_ctr_ctrl
// Brief    : AES-128 CTR-mode sequencer; drives an external AES core and
//            XORs its keystream onto a valid/ready data stream.
// Revision : 1.0 - initial release
// =====================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_ctr_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic [127:0] data_in,
  input  logic         data_vld,
  output logic         data_rdy,
  output logic [127:0] data_out,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         busy,
  output logic [127:0] Kin,
  output logic [127:0] Din,
  output logic         Krdy,
  output logic         Drdy,
  input  logic         core_bsy,
  input  logic         core_kvld,
  input  logic         core_dvld,
  input  logic [127:0] core_dout
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_KLOAD = 3'd1;
  localparam logic [2:0] c_KWAIT = 3'd2;
  localparam logic [2:0] c_GEN   = 3'd3;
  localparam logic [2:0] c_GWAIT = 3'd4;
  localparam logic [2:0] c_HOLD  = 3'd5;

  logic [2:0]   r_state;
  logic [2:0]   w_state_next;
  logic [127:0] r_key;
  logic [127:0] r_ctr;
  logic [127:0] r_ks;
  logic         r_ks_full;
  logic [127:0] r_data_out;
  logic         r_out_vld;
  logic [127:0] w_ctr_inc;
  logic         w_load;
  logic         w_accept;
  logic         w_ks_capture;

  // Only the low CTR_W bits count; the upper part of the block is fixed per session.
  generate
    if (CTR_W >= 128) begin : g_ctr_full
      assign w_ctr_inc = r_ctr + 128'd1;
    end else begin : g_ctr_part
      assign w_ctr_inc = {r_ctr[127:CTR_W], r_ctr[CTR_W-1:0] + CTR_W'(1)};
    end
  endgenerate

  assign w_load       = (r_state == c_IDLE) & start & ~core_bsy & ~abort;
  assign w_accept     = data_vld & data_rdy & ~abort;
  assign w_ks_capture = (r_state == c_GWAIT) & core_dvld & ~abort;

  assign Kin      = r_key;
  assign Din      = r_ctr;
  assign data_out = r_data_out;
  assign out_vld  = r_out_vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (start && !core_bsy) w_state_next = c_KLOAD;
        c_KLOAD: w_state_next = c_KWAIT;
        c_KWAIT: if (core_kvld) w_state_next = c_GEN;
        c_GEN:   if (!core_bsy) w_state_next = c_GWAIT;
        c_GWAIT: if (core_dvld) w_state_next = c_HOLD;
        c_HOLD:  if (w_accept) w_state_next = c_GEN;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  // Core strobes are also masked by abort so no request is launched as the session dies.
  always_comb begin
    busy     = (r_state != c_IDLE);
    Krdy     = (r_state == c_KLOAD) & ~abort;
    Drdy     = (r_state == c_GEN) & ~core_bsy & ~abort;
    data_rdy = (r_state == c_HOLD) & r_ks_full & (~r_out_vld | out_rdy);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key      <= '0;
      r_ctr      <= '0;
      r_ks       <= '0;
      r_ks_full  <= 1'b0;
      r_data_out <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      if (w_load) begin
        r_key <= key_in;
        r_ctr <= iv_in;
      end else if (w_ks_capture) begin
        r_ctr <= w_ctr_inc;
      end

      if (w_ks_capture) begin
        r_ks <= core_dout;
      end

      if (abort) begin
        r_ks_full <= 1'b0;
      end else if (w_ks_capture) begin
        r_ks_full <= 1'b1;
      end else if (w_accept) begin
        r_ks_full <= 1'b0;
      end

      // An accept on a draining edge reloads the slot and keeps it valid.
      if (abort) begin
        r_out_vld <= 1'b0;
      end else if (w_accept) begin
        r_data_out <= data_in ^ r_ks;
        r_out_vld  <= 1'b1;
      end else if (out_rdy) begin
        r_out_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
